// File: rtl/sram_1rw_mask_gen.sv
// Single-port masked SRAM behavioural model with optional output register and post-reset clear.
// Latency: read data and rvalid 1 cycle after the accepted read (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: RW0_ready gates acceptance; accesses with RW0_ready=0 are dropped with no side effects.
//
// Ports: RW0_clk/RW0_rst_n (async active-low), RW0_addr/RW0_en/RW0_wmode/RW0_wmask/RW0_wdata
// access request, RW0_ready accept flag, RW0_rvalid one-cycle read strobe, RW0_rdata held read data.
// Optional macro SRAM_MODEL_INIT_CLEAR_EN compiles in a RESET->CLEAR->IDLE sweep that zeroes every
// entry after reset and holds RW0_ready low until the sweep completes.
module sram_1rw_mask_gen #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 26,
    parameter int MASK_GRAN = 13,
    parameter int ADDR_W    = 4,
    parameter int OUT_REG   = 0
) (
    input  logic                       RW0_clk,
    input  logic                       RW0_rst_n,
    input  logic [ADDR_W-1:0]          RW0_addr,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [WIDTH/MASK_GRAN-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]           RW0_wdata,
    output logic                       RW0_ready,
    output logic                       RW0_rvalid,
    output logic [WIDTH-1:0]           RW0_rdata
);

    localparam int LANES = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    logic in_range;
    logic acc;
    logic wr_acc;
    logic rd_acc;

    // Zero-extend so that DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, RW0_addr} < DEPTH_V);
    assign acc      = RW0_en & ready;
    assign wr_acc   = acc & RW0_wmode & in_range;
    assign rd_acc   = acc & ~RW0_wmode;

    // Array storage is deliberately not reset. The clear sweep owns the
    // array while it runs; user writes cannot collide with it because
    // ready is low for the whole sweep.
    always_ff @(posedge RW0_clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (RW0_wmask[i]) begin
                    mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // First read stage: captures only on accepted reads, so data holds otherwise.
    logic [WIDTH-1:0] rd_q;
    logic             rv_q;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_acc;
            if (rd_acc) begin
                rd_q <= in_range ? mem[RW0_addr] : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] rd_q2;
            logic             rv_q2;

            always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
                if (!RW0_rst_n) begin
                    rd_q2 <= '0;
                    rv_q2 <= 1'b0;
                end else begin
                    rv_q2 <= rv_q;
                    if (rv_q) begin
                        rd_q2 <= rd_q;
                    end
                end
            end

            assign RW0_rdata  = rd_q2;
            assign RW0_rvalid = rv_q2;
        end else begin : g_no_out_reg
            assign RW0_rdata  = rd_q;
            assign RW0_rvalid = rv_q;
        end
    endgenerate

`ifdef SRAM_MODEL_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // RESET is only observable between reset release and the first edge;
    // the async reset puts the FSM back there from any state.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    assign ready   = (state == ST_IDLE);
    assign clr_idx = clr_cnt;
`else
    logic ready_q;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready   = ready_q;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    assign RW0_ready = ready;

endmodule

// File: tb/tb_sram_1rw_mask_gen.sv
// Directed bench for sram_1rw_mask_gen: three instances share clock, reset and request
// fields; u0 is the default build, u1 adds the output register, u2 has DEPTH=12.
// Clear-sweep checks are compiled only when SRAM_MODEL_INIT_CLEAR_EN is defined.
module tb_sram_1rw_mask_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr;
    logic        en0, en1, en2;
    logic        wmode;
    logic [1:0]  wmask;
    logic [25:0] wdata;

    logic        rdy0, rdy1, rdy2;
    logic        rv0, rv1, rv2;
    logic [25:0] rd0, rd1, rd2;

    int checks = 0;
    int passed = 0;
    int n;

    always #5 clk = ~clk;

    sram_1rw_mask_gen u0 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en0),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_ready(rdy0), .RW0_rvalid(rv0), .RW0_rdata(rd0)
    );

    sram_1rw_mask_gen #(.OUT_REG(1)) u1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en1),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_ready(rdy1), .RW0_rvalid(rv1), .RW0_rdata(rd1)
    );

    sram_1rw_mask_gen #(.DEPTH(12)) u2 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en2),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_ready(rdy2), .RW0_rvalid(rv2), .RW0_rdata(rd2)
    );

    // Distinct, nonzero fill pattern per address.
    function automatic logic [25:0] val(input int a);
        logic [31:0] p;
        p = (a + 1) * 32'h0135_79BD;
        return p[25:0] ^ 26'h2A5_5A5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [25:0] d, input logic [1:0] m);
        addr  = a;
        wmode = 1'b1;
        wdata = d;
        wmask = m;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        addr  = a;
        wmode = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
        rst_n = 1'b0;
        repeat (2) tick();

        chk("rst_ready0", rdy0, 0);
        chk("rst_rvalid0", rv0, 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_rvalid1", rv1, 0);
        chk("rst_rdata1", rd1, 0);
        chk("rst_ready2", rdy2, 0);

        rst_n = 1'b1;
        tick();

`ifdef SRAM_MODEL_INIT_CLEAR_EN
        chk("clr_ready_first_edge", rdy0, 0);
        // Hold a write request for the whole sweep; it must be dropped.
        en0 = 1'b1; wmode = 1'b1; addr = 4'd2; wdata = 26'h3FFFFFF; wmask = 2'b11;
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        en0 = 1'b0;
        chk("clr_ready_cycles", n, 16);
        en0 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("clr_read_zero", rd0, 0);
        end
        en0 = 1'b0;
`else
        chk("ready0_after_release", rdy0, 1);
        chk("ready1_after_release", rdy1, 1);
        chk("ready2_after_release", rdy2, 1);
`endif

        // Masked write then read-back.
        en0 = 1'b1;
        wr(4'd3, 26'h3FFFFFF, 2'b11);
        wr(4'd3, 26'h0000000, 2'b01);
        chk("wr_no_rvalid", rv0, 0);
        rd(4'd3);
        chk("mask_rdata", rd0, 26'h3FFE000);
        chk("mask_rvalid", rv0, 1);
        en0 = 1'b0;
        tick();
        chk("rvalid_one_cycle", rv0, 0);
        chk("rdata_hold_idle", rd0, 26'h3FFE000);
        en0 = 1'b1;
        wr(4'd3, 26'h0000000, 2'b00);
        chk("wr_keeps_rdata", rd0, 26'h3FFE000);
        rd(4'd3);
        chk("zero_mask_write", rd0, 26'h3FFE000);
        wr(4'd3, 26'h1555555, 2'b10);
        rd(4'd3);
        chk("upper_lane_write", rd0, 26'h1554000);
        en0 = 1'b0;

        // Output-register latency and hold.
        en1 = 1'b1;
        wr(4'd5, 26'h0ABCDEF, 2'b11);
        rd(4'd5);
        chk("or1_not_yet_valid", rv1, 0);
        en1 = 1'b0;
        tick();
        chk("or1_rvalid", rv1, 1);
        chk("or1_rdata", rd1, 26'h0ABCDEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("or1_hold_rvalid", rv1, 0);
            chk("or1_hold_rdata", rd1, 26'h0ABCDEF);
        end

        // Write followed immediately by read of the same entry.
        en0 = 1'b1;
        wr(4'd7, 26'h1234567, 2'b11);
        rd(4'd7);
        chk("wr_then_rd", rd0, 26'h1234567);
        chk("wr_then_rd_rvalid", rv0, 1);

        // Fill, then back-to-back reads; u2 sees 12..15 as out of range.
        en2 = 1'b1;
        for (int a = 0; a < 16; a++) wr(4'(a), val(a), 2'b11);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("b2b_rvalid0", rv0, 1);
            chk("b2b_rdata0", rd0, val(a));
            chk("b2b_rvalid2", rv2, 1);
            chk("b2b_rdata2", rd2, (a < 12) ? val(a) : 26'h0);
        end
        en0 = 1'b0;

        // Out-of-range write and read on the DEPTH=12 instance.
        rd(4'd11);
        chk("oor_pre_read", rd2, val(11));
        wr(4'd13, 26'h3FFFFFF, 2'b11);
        chk("oor_wr_no_rvalid", rv2, 0);
        chk("oor_wr_keeps_rdata", rd2, val(11));
        rd(4'd14);
        chk("oor_rd_rdata", rd2, 0);
        chk("oor_rd_rvalid", rv2, 1);
        for (int a = 0; a < 12; a++) begin
            rd(4'(a));
            chk("oor_no_alias", rd2, val(a));
        end
        en2 = 1'b0;
        tick();
        chk("rdata0_hold_end", rd0, val(15));

`ifdef SRAM_MODEL_INIT_CLEAR_EN
        rst_n = 1'b0;
        #1;
        chk("rst_clears_rdata", rd0, 0);
        chk("rst_clears_ready", rdy0, 0);
        #1;
        rst_n = 1'b1;
        tick();
        repeat (9) tick();
        chk("midclr_ready_low", rdy0, 0);
        rst_n = 1'b0;
        #1;
        chk("midclr_rdata", rd0, 0);
        chk("midclr_rvalid", rv0, 0);
        chk("midclr_ready", rdy0, 0);
        #1;
        rst_n = 1'b1;
        tick();
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("midclr_restart_cycles", n, 16);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
